// File: rtl/rf_pkg.sv
// Shared defaults and reset constants for the rename register file.
package rf_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int ROB_WIDTH_DEF = 4;
  localparam int NUM_REGS_DEF  = 32;

  // Wide enough for any supported XLEN / ROB_WIDTH; sliced at the use site.
  localparam logic [63:0] RST_DATA = 64'h0;
  localparam logic [31:0] RST_TAG  = 32'h0;
  localparam logic        RST_BUSY = 1'b0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: entry lookup, x0 hardwiring and commit forwarding.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  localparam int REG_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [REG_WIDTH-1:0]                id,
  input  logic [NUM_REGS-1:0][XLEN-1:0]       data_arr,
  input  logic [NUM_REGS-1:0][ROB_WIDTH-1:0]  tag_arr,
  input  logic [NUM_REGS-1:0]                 busy_arr,
  input  logic                                fwd_valid,
  input  logic [REG_WIDTH-1:0]                fwd_rd,
  input  logic [XLEN-1:0]                     fwd_data,
  output logic [XLEN-1:0]                     data,
  output logic [ROB_WIDTH-1:0]                tag,
  output logic                                ready
);

  always_comb begin
    data  = data_arr[id];
    tag   = tag_arr[id];
    ready = ~busy_arr[id];
    if (id == '0) begin
      data  = '0;
      tag   = '0;
      ready = 1'b1;
    end else if (fwd_valid && (fwd_rd == id)) begin
      // Tag is left as the stored mapping; only value and readiness are forwarded.
      data  = fwd_data;
      ready = 1'b1;
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tags and busy bits.
// Optional feature: define RENAME_RF_BYPASS_EN to forward a same-cycle retiring commit to the read ports.
module rename_reg_file
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  localparam int REG_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid_in,
  input  logic [REG_WIDTH-1:0] issue_rd_in,
  input  logic [ROB_WIDTH-1:0] issue_tag_in,
  input  logic [REG_WIDTH-1:0] rs1_id_in,
  input  logic [REG_WIDTH-1:0] rs2_id_in,
  output logic [XLEN-1:0]      rs1_data_out,
  output logic [XLEN-1:0]      rs2_data_out,
  output logic [ROB_WIDTH-1:0] rs1_tag_out,
  output logic [ROB_WIDTH-1:0] rs2_tag_out,
  output logic                 rs1_ready_out,
  output logic                 rs2_ready_out,
  input  logic                 commit_valid_in,
  input  logic [REG_WIDTH-1:0] commit_rd_in,
  input  logic [ROB_WIDTH-1:0] commit_tag_in,
  input  logic [XLEN-1:0]      commit_data_in,
  input  logic                 flush_in,
  output logic [REG_WIDTH:0]   busy_cnt_out
);

  logic [NUM_REGS-1:0][XLEN-1:0]      data_q;
  logic [NUM_REGS-1:0][ROB_WIDTH-1:0] tag_q;
  logic [NUM_REGS-1:0]                busy_q;
  logic [NUM_REGS-1:0]                busy_next;

  logic issue_fire;
  logic commit_fire;
  logic commit_hit;
  logic flush_fire;
  logic fwd_valid;

  function automatic logic [REG_WIDTH:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [REG_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + {{REG_WIDTH{1'b0}}, v[i]};
    return n;
  endfunction

  assign flush_fire  = rdy_in & flush_in;
  assign issue_fire  = rdy_in & issue_valid_in & ~flush_in & (issue_rd_in != '0);
  assign commit_fire = rdy_in & commit_valid_in & (commit_rd_in != '0);
  assign commit_hit  = commit_fire & busy_q[commit_rd_in] & (tag_q[commit_rd_in] == commit_tag_in);

`ifdef RENAME_RF_BYPASS_EN
  assign fwd_valid = commit_hit;
`else
  assign fwd_valid = 1'b0;
`endif

  always_comb begin
    busy_next = busy_q;
    if (flush_fire) begin
      busy_next = '0;
    end else begin
      // A rename landing on the retiring register wins: the newer producer stays pending.
      if (commit_hit && !(issue_fire && (issue_rd_in == commit_rd_in)))
        busy_next[commit_rd_in] = 1'b0;
      if (issue_fire)
        busy_next[issue_rd_in] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= RST_DATA[XLEN-1:0];
        tag_q[i]  <= RST_TAG[ROB_WIDTH-1:0];
        busy_q[i] <= RST_BUSY;
      end
      busy_cnt_out <= '0;
    end else if (rdy_in) begin
      if (commit_fire) data_q[commit_rd_in] <= commit_data_in;
      if (issue_fire)  tag_q[issue_rd_in]   <= issue_tag_in;
      busy_q       <= busy_next;
      busy_cnt_out <= popcount(busy_next);
    end
  end

  rf_read_port #(
    .XLEN      (XLEN),
    .ROB_WIDTH (ROB_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_rs1 (
    .id        (rs1_id_in),
    .data_arr  (data_q),
    .tag_arr   (tag_q),
    .busy_arr  (busy_q),
    .fwd_valid (fwd_valid),
    .fwd_rd    (commit_rd_in),
    .fwd_data  (commit_data_in),
    .data      (rs1_data_out),
    .tag       (rs1_tag_out),
    .ready     (rs1_ready_out)
  );

  rf_read_port #(
    .XLEN      (XLEN),
    .ROB_WIDTH (ROB_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_rs2 (
    .id        (rs2_id_in),
    .data_arr  (data_q),
    .tag_arr   (tag_q),
    .busy_arr  (busy_q),
    .fwd_valid (fwd_valid),
    .fwd_rd    (commit_rd_in),
    .fwd_data  (commit_data_in),
    .data      (rs2_data_out),
    .tag       (rs2_tag_out),
    .ready     (rs2_ready_out)
  );

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file: directed scenarios plus a short random run against a reference model.
module tb_rename_reg_file;

  localparam int XLEN = 32, ROB_WIDTH = 4, NUM_REGS = 32, RW = 5;

  logic            clk_in = 1'b0;
  logic            rst_n_in, rdy_in, issue_valid_in, commit_valid_in, flush_in;
  logic [RW-1:0]   issue_rd_in, rs1_id_in, rs2_id_in, commit_rd_in;
  logic [ROB_WIDTH-1:0] issue_tag_in, commit_tag_in, rs1_tag_out, rs2_tag_out;
  logic [XLEN-1:0] commit_data_in, rs1_data_out, rs2_data_out;
  logic            rs1_ready_out, rs2_ready_out;
  logic [RW:0]     busy_cnt_out;

  rename_reg_file #(.XLEN(XLEN), .ROB_WIDTH(ROB_WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in), .issue_tag_in(issue_tag_in),
    .rs1_id_in(rs1_id_in), .rs2_id_in(rs2_id_in),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .rs1_tag_out(rs1_tag_out), .rs2_tag_out(rs2_tag_out),
    .rs1_ready_out(rs1_ready_out), .rs2_ready_out(rs2_ready_out),
    .commit_valid_in(commit_valid_in), .commit_rd_in(commit_rd_in),
    .commit_tag_in(commit_tag_in), .commit_data_in(commit_data_in),
    .flush_in(flush_in), .busy_cnt_out(busy_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  localparam int K_D1 = 0, K_T1 = 1, K_R1 = 2, K_CNT = 3, K_D2 = 4, K_T2 = 5, K_R2 = 6;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]      m_data [NUM_REGS];
  logic [ROB_WIDTH-1:0] m_tag  [NUM_REGS];
  logic                 m_busy [NUM_REGS];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_D1:    return rs1_data_out;
      K_T1:    return {28'b0, rs1_tag_out};
      K_R1:    return {31'b0, rs1_ready_out};
      K_CNT:   return {26'b0, busy_cnt_out};
      K_D2:    return rs2_data_out;
      K_T2:    return {28'b0, rs2_tag_out};
      K_R2:    return {31'b0, rs2_ready_out};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.name, observe(e.kind), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; issue_valid_in = 1'b0; commit_valid_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic [ROB_WIDTH-1:0] tag);
    issue_valid_in = 1'b1; issue_rd_in = rd; issue_tag_in = tag;
  endtask

  task automatic commit(input logic [RW-1:0] rd, input logic [ROB_WIDTH-1:0] tag, input logic [XLEN-1:0] d);
    commit_valid_in = 1'b1; commit_rd_in = rd; commit_tag_in = tag; commit_data_in = d;
  endtask

  // Reference model of the expected read result for one register, given current inputs.
  task automatic model_read(input logic [RW-1:0] id, output logic [31:0] d,
                            output logic [31:0] t, output logic [31:0] r);
    d = m_data[id]; t = {28'b0, m_tag[id]}; r = {31'b0, ~m_busy[id]};
    if (id == 0) begin
      d = 0; t = 0; r = 1;
    end
`ifdef RENAME_RF_BYPASS_EN
    else if (rdy_in && commit_valid_in && commit_rd_in == id && m_busy[id] && m_tag[id] == commit_tag_in) begin
      d = commit_data_in; r = 1;
    end
`endif
  endtask

  task automatic model_edge();
    logic hit;
    int   n;
    if (rdy_in) begin
      hit = commit_valid_in && commit_rd_in != 0 && m_busy[commit_rd_in] && m_tag[commit_rd_in] == commit_tag_in;
      if (commit_valid_in && commit_rd_in != 0) m_data[commit_rd_in] = commit_data_in;
      if (flush_in) begin
        for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
      end else begin
        if (hit && !(issue_valid_in && issue_rd_in == commit_rd_in)) m_busy[commit_rd_in] = 1'b0;
        if (issue_valid_in && issue_rd_in != 0) begin
          m_tag[issue_rd_in] = issue_tag_in;
          m_busy[issue_rd_in] = 1'b1;
        end
      end
    end
    n = 0;
    for (int i = 0; i < NUM_REGS; i++) n += int'(m_busy[i]);
    push("rand_cnt", K_CNT, n);
  endtask

  initial begin
    logic [31:0] d, t, r;
    rst_n_in = 1'b0; idle();
    issue_rd_in = '0; issue_tag_in = '0; commit_rd_in = '0; commit_tag_in = '0;
    commit_data_in = '0; rs1_id_in = '0; rs2_id_in = '0;
    tick(); tick();
    rst_n_in = 1'b1;

    // Reset state
    rs1_id_in = 5; rs2_id_in = 0; #1;
    push("rst_d5", K_D1, 0); push("rst_r5", K_R1, 1); push("rst_cnt", K_CNT, 0);
    push("rst_d0", K_D2, 0); push("rst_r0", K_R2, 1);
    drain();

    // Issue x5 tag 3; same-cycle read sees the old mapping
    issue(5, 3); rs1_id_in = 5; #1;
    push("pre_issue_r5", K_R1, 1); push("pre_issue_t5", K_T1, 0);
    drain();
    tick(); idle();
    push("iss_t5", K_T1, 3); push("iss_r5", K_R1, 0); push("iss_cnt", K_CNT, 1);
    drain();

    // Matching commit
    commit(5, 3, 32'hDEADBEEF); #1;
`ifdef RENAME_RF_BYPASS_EN
    push("cmt_same_r5", K_R1, 1); push("cmt_same_d5", K_D1, 32'hDEADBEEF);
`else
    push("cmt_same_r5", K_R1, 0);
`endif
    drain();
    tick(); idle();
    push("cmt_r5", K_R1, 1); push("cmt_d5", K_D1, 32'hDEADBEEF); push("cmt_cnt", K_CNT, 0);
    drain();

    // Commit and re-issue of the same register in one cycle
    issue(5, 3); tick(); idle();
    commit(5, 3, 32'h1111_1111); issue(5, 7); tick(); idle();
    push("reiss_d5", K_D1, 32'h1111_1111); push("reiss_t5", K_T1, 7);
    push("reiss_r5", K_R1, 0); push("reiss_cnt", K_CNT, 1);
    drain();

    // Stale-tag commit: data written, busy kept
    commit(5, 7, 32'h5); tick(); idle();
    issue(5, 3); tick(); idle();
    commit(5, 2, 32'h2222_2222); tick(); idle();
    push("stale_d5", K_D1, 32'h2222_2222); push("stale_r5", K_R1, 0);
    push("stale_t5", K_T1, 3); push("stale_cnt", K_CNT, 1);
    drain();

    // Same-cycle visibility of a retiring commit
    commit(5, 3, 32'h42); #1;
`ifdef RENAME_RF_BYPASS_EN
    push("byp_r5", K_R1, 1); push("byp_d5", K_D1, 32'h42);
`else
    push("nobyp_r5", K_R1, 0); push("nobyp_d5", K_D1, 32'h2222_2222);
`endif
    drain();
    tick(); idle();
    push("post_byp_r5", K_R1, 1); push("post_byp_d5", K_D1, 32'h42); push("post_byp_cnt", K_CNT, 0);
    drain();

    // Flush with three busy, plus a same-cycle issue and commit data write
    issue(3, 1); tick(); issue(4, 2); tick(); issue(6, 5); tick(); idle();
    push("pre_flush_cnt", K_CNT, 3);
    drain();
    flush_in = 1'b1; issue(9, 4); commit(4, 9, 32'h77); tick(); idle();
    rs1_id_in = 9; rs2_id_in = 4; #1;
    push("flush_cnt", K_CNT, 0); push("flush_r9", K_R1, 1);
    push("flush_r4", K_R2, 1); push("flush_d4", K_D2, 32'h77);
    drain();
    rs1_id_in = 3; rs2_id_in = 6; #1;
    push("flush_r3", K_R1, 1); push("flush_r6", K_R2, 1);
    drain();

    // Register 0 ignores issue and commit
    issue(0, 5); commit(0, 0, 32'hFFFF); tick(); idle();
    rs1_id_in = 0; #1;
    push("x0_d", K_D1, 0); push("x0_t", K_T1, 0); push("x0_r", K_R1, 1); push("x0_cnt", K_CNT, 0);
    drain();

    // Stall holds everything
    rdy_in = 1'b0; issue(7, 2); commit(4, 0, 32'h99); tick(); idle();
    rs1_id_in = 7; rs2_id_in = 4; #1;
    push("stall_r7", K_R1, 1); push("stall_d4", K_D2, 32'h77); push("stall_cnt", K_CNT, 0);
    drain();
    issue(7, 2); tick(); idle();
    rdy_in = 1'b0; flush_in = 1'b1; tick(); idle();
    push("stall_flush_r7", K_R1, 0); push("stall_flush_cnt", K_CNT, 1);
    drain();

    // Reset overrides concurrent activity
    rst_n_in = 1'b0; issue(8, 1); tick(); rst_n_in = 1'b1; idle();
    #1;
    push("rst2_r7", K_R1, 1); push("rst2_d7", K_D1, 0); push("rst2_d4", K_D2, 0); push("rst2_cnt", K_CNT, 0);
    drain();

    // Random traffic checked against the reference model
    for (int i = 0; i < NUM_REGS; i++) begin
      m_data[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      rdy_in          = ($urandom_range(0, 9) != 0);
      issue_valid_in  = ($urandom_range(0, 1) != 0);
      issue_rd_in     = RW'($urandom_range(0, 7));
      issue_tag_in    = ROB_WIDTH'($urandom);
      commit_valid_in = ($urandom_range(0, 2) != 0);
      commit_rd_in    = RW'($urandom_range(0, 7));
      commit_tag_in   = ($urandom_range(0, 2) != 0) ? m_tag[commit_rd_in] : ROB_WIDTH'($urandom);
      commit_data_in  = $urandom;
      flush_in        = ($urandom_range(0, 19) == 0);
      rs1_id_in       = RW'($urandom_range(0, 7));
      rs2_id_in       = RW'($urandom_range(0, 7));
      #1;
      model_read(rs1_id_in, d, t, r);
      push("rand_d1", K_D1, d); push("rand_t1", K_T1, t); push("rand_r1", K_R1, r);
      model_read(rs2_id_in, d, t, r);
      push("rand_d2", K_D2, d); push("rand_t2", K_T2, t); push("rand_r2", K_R2, r);
      drain();
      model_edge();
      tick();
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32: architectural register data width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4: ROB tag width.
REQ-003 SHALL have parameter NUM_REGS, default 32: number of architectural registers, a power of two; REG_WIDTH = log2(NUM_REGS).
REQ-004 SHALL have port clk_in, input, 1: the single clock; one clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port rdy_in, input, 1: stall when low; no state changes.
REQ-007 SHALL have ports issue_valid_in (in, 1), issue_rd_in (in, REG_WIDTH), issue_tag_in (in, ROB_WIDTH): rename rd to a ROB tag.
REQ-008 SHALL have ports rs1_id_in, rs2_id_in (in, REG_WIDTH): source selects.
REQ-009 SHALL have ports rs1_data_out, rs2_data_out (out, XLEN); rs1_tag_out, rs2_tag_out (out, ROB_WIDTH); rs1_ready_out, rs2_ready_out (out, 1).
REQ-010 SHALL have ports commit_valid_in (in, 1), commit_rd_in (in, REG_WIDTH), commit_tag_in (in, ROB_WIDTH), commit_data_in (in, XLEN): ROB retirement.
REQ-011 SHALL have port flush_in, input, 1: misprediction; discard all renames.
REQ-012 SHALL have port busy_cnt_out, output, REG_WIDTH+1: count of renamed (busy) registers.

Function
REQ-013 SHALL hold, per entry, data (XLEN), tag (ROB_WIDTH) and a busy bit; busy=1 means the value is pending in the ROB.
REQ-014 SHALL drive read ports combinationally: data = entry data, tag = entry tag, ready = ~busy.
REQ-015 SHALL hardwire register 0: reads give data 0, tag 0, ready 1; issue and commit to rd 0 are ignored.
REQ-016 SHALL, on issue (rdy_in & issue_valid_in & ~flush_in), set tag[rd] <= issue_tag_in and busy[rd] <= 1 at the next edge.
REQ-017 SHALL have same-cycle reads see pre-issue state, so rs==rd returns the old mapping.
REQ-018 SHALL, on commit, always write data[commit_rd_in] <= commit_data_in.
REQ-019 SHALL, on commit, clear busy only if busy & tag == commit_tag_in, and only if no same-cycle issue targets that rd; otherwise the newer rename stays busy.
REQ-020 SHALL, on flush (rdy_in & flush_in), clear all busy bits next edge and ignore issue that cycle; a same-cycle commit data write still occurs.
REQ-021 SHALL, with rdy_in low, ignore issue, commit and flush; all state is held.
REQ-022 SHALL register busy_cnt_out as the exact population count of busy bits after each edge, range 0..NUM_REGS-1.

Reset
REQ-023 SHALL, when rst_n_in is low at a clock edge, set all data 0, tags 0, busy 0 and busy_cnt_out 0, overriding rdy_in, issue, commit and flush.
REQ-024 SHALL, after reset, report every read port as data 0, ready 1.

Configuration
REQ-025 SHALL, with RENAME_RF_BYPASS_EN defined, forward a same-cycle matching commit (commit_valid_in & rdy_in & busy & tag match, rd equal) to a read port: data = commit_data_in, ready = 1.
REQ-026 SHALL, without RENAME_RF_BYPASS_EN, give ready = ~busy only; the commit becomes visible the next cycle.

Structure
REQ-027 SHALL place default widths (XLEN, ROB_WIDTH, NUM_REGS) and the reset constants in shared package rf_pkg.
REQ-028 SHALL implement one read port (lookup + optional bypass) as sub-module rf_read_port, instantiated twice.

Verification
REQ-029 SHALL cover: reset -> read x5 gives data 0, ready 1; busy_cnt_out 0.
REQ-030 SHALL cover: issue rd=5, tag=3; next cycle read x5 -> tag 3, ready 0; busy_cnt_out 1; commit rd=5, tag=3, data=0xDEADBEEF -> next cycle ready 1, data 0xDEADBEEF, count 0.
REQ-031 SHALL cover: x5 busy tag 3; same cycle commit tag 3 and issue rd=5 tag 7 -> data updated, x5 busy with tag 7.
REQ-032 SHALL cover: x5 busy tag 3, commit rd=5 tag 2 -> data written, busy stays set.
REQ-033 SHALL cover: three registers busy, flush with issue rd=9 -> all ready, x9 not busy, count 0.
REQ-034 SHALL cover: bypass on, x5 busy tag 3, commit tag 3 data 0x42 while reading x5 -> same cycle ready 1, data 0x42; bypass off -> ready 0 this cycle, 1 the next.
